// File: rtl/ttt_core_scheduler.sv
// ttt_core_scheduler
// Time-multiplexes one evaluation core over NUM_PROCESSORS processors. A tick
// starts a sweep over ids 0..NUM_PROCESSORS-1. Start/stop tokens returned by
// the core are captured into a one-deep valid/ready event register, which
// stalls the sweep while it is full. Between sweeps, single-cycle programming
// passes drive an instruction and data word to one processor.
// Build option: define TTT_SCHED_OVERRUN_CNT_EN to make overrun an 8-bit
// saturating count of ignored ticks; otherwise overrun[0] is a sticky flag.
module ttt_core_scheduler #(
   parameter int  NUM_PROCESSORS = 10,
   parameter int  PROG_WIDTH     = 8,
   localparam int ID_W           = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1
) (
   input  logic                  clock_fast,
   input  logic                  reset_n,
   input  logic                  tick,
   output logic [ID_W-1:0]       processor_id,
   output logic                  core_valid,
   input  logic [1:0]            token_startstop,
   output logic                  event_valid,
   input  logic                  event_ready,
   output logic [ID_W-1:0]       event_id,
   output logic [1:0]            event_type,
   input  logic                  prog_req,
   input  logic [ID_W-1:0]       prog_id,
   input  logic [2:0]            prog_instr,
   input  logic [PROG_WIDTH-1:0] prog_data_in,
   output logic                  prog_ack,
   output logic                  prog_err,
   output logic [2:0]            instruction,
   output logic [PROG_WIDTH-1:0] prog_data,
   output logic                  sweep_busy,
   output logic                  sweep_done,
   output logic [7:0]            overrun
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      PROG  = 2'd2
   } state_e;

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PROCESSORS - 1);

   state_e                state_q;
   logic [ID_W-1:0]       processor_id_q;
   logic [2:0]            instruction_q;
   logic [PROG_WIDTH-1:0] prog_data_q;
   logic                  prog_ack_q;
   logic                  prog_err_q;
   logic                  sweep_done_q;

   logic                  event_valid_q, event_valid_d;
   logic [ID_W-1:0]       event_id_q, event_id_d;
   logic [1:0]            event_type_q, event_type_d;
   logic [7:0]            overrun_q, overrun_d;

   logic                  core_valid_w;
   logic                  event_load;
   logic                  tick_overrun;
   logic                  prog_id_ok;

   // The core may evaluate only when the event register can take its result.
   assign core_valid_w = (state_q == SWEEP) && (!event_valid_q || event_ready);
   assign event_load   = core_valid_w && (token_startstop != 2'b00);
   assign tick_overrun = tick && (state_q != IDLE);
   assign prog_id_ok   = (32'(prog_id) < NUM_PROCESSORS);

   // Event register next state: a new load takes priority over a drain.
   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      event_valid_d = event_valid_q;
      event_id_d    = event_id_q;
      event_type_d  = event_type_q;
      if (event_load) begin
         event_valid_d = 1'b1;
         event_id_d    = processor_id_q;
         event_type_d  = token_startstop;
      end else if (event_valid_q && event_ready) begin
         event_valid_d = 1'b0;
      end
   end

   // Overrun next state: saturating counter or sticky flag.
   always_comb begin
      overrun_d = overrun_q;
      if (tick_overrun) begin
`ifdef TTT_SCHED_OVERRUN_CNT_EN
         if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
`else
         overrun_d = 8'h01;
`endif
      end
   end

   // Control FSM with registered outputs: sweep sequencing and programming passes.
   always_ff @(posedge clock_fast or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         processor_id_q <= '0;
         instruction_q  <= 3'b000;
         prog_data_q    <= '0;
         prog_ack_q     <= 1'b0;
         prog_err_q     <= 1'b0;
         sweep_done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         prog_ack_q    <= 1'b0;
         prog_err_q    <= 1'b0;
         sweep_done_q  <= 1'b0;
         instruction_q <= 3'b000;
         unique case (state_q)
            IDLE: begin
               if (tick) begin
                  state_q        <= SWEEP;
                  processor_id_q <= '0;
               end else if (prog_req) begin
                  state_q        <= PROG;
                  processor_id_q <= prog_id;
                  prog_data_q    <= prog_data_in;
                  instruction_q  <= prog_id_ok ? prog_instr : 3'b000;
                  prog_ack_q     <= 1'b1;
                  prog_err_q     <= !prog_id_ok;
               end
            end
            SWEEP: begin
               if (core_valid_w) begin
                  if (processor_id_q == LAST_ID) begin
                     state_q        <= IDLE;
                     processor_id_q <= '0;
                     sweep_done_q   <= 1'b1;
                  end else begin
                     processor_id_q <= processor_id_q + ID_W'(1);
                  end
               end
            end
            PROG: begin
               state_q        <= IDLE;
               processor_id_q <= '0;
            end
            default: begin
               state_q        <= IDLE;
               processor_id_q <= '0;
            end
         endcase
      end
   end

   // Event register and overrun state.
   always_ff @(posedge clock_fast or negedge reset_n) begin
      if (!reset_n) begin
         event_valid_q <= 1'b0;
         event_id_q    <= '0;
         event_type_q  <= 2'b00;
         overrun_q     <= 8'h00;
      end else begin
         event_valid_q <= event_valid_d;
         event_id_q    <= event_id_d;
         event_type_q  <= event_type_d;
         overrun_q     <= overrun_d;
      end
   end

   assign processor_id = processor_id_q;
   assign core_valid   = core_valid_w;
   assign event_valid  = event_valid_q;
   assign event_id     = event_id_q;
   assign event_type   = event_type_q;
   assign prog_ack     = prog_ack_q;
   assign prog_err     = prog_err_q;
   assign instruction  = instruction_q;
   assign prog_data    = prog_data_q;
   assign sweep_busy   = (state_q == SWEEP);
   assign sweep_done   = sweep_done_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_ttt_core_scheduler.sv
// Directed testbench for ttt_core_scheduler: sweeps, event back-pressure,
// programming passes, overrun counting and asynchronous reset.
module tb_ttt_core_scheduler;

   localparam int N  = 10;
   localparam int PW = 8;
   localparam int IW = 4;

`ifdef TTT_SCHED_OVERRUN_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clock_fast = 1'b0;
   logic          reset_n;
   logic          tick;
   logic [IW-1:0] processor_id;
   logic          core_valid;
   logic [1:0]    token_startstop;
   logic          event_valid;
   logic          event_ready;
   logic [IW-1:0] event_id;
   logic [1:0]    event_type;
   logic          prog_req;
   logic [IW-1:0] prog_id;
   logic [2:0]    prog_instr;
   logic [PW-1:0] prog_data_in;
   logic          prog_ack;
   logic          prog_err;
   logic [2:0]    instruction;
   logic [PW-1:0] prog_data;
   logic          sweep_busy;
   logic          sweep_done;
   logic [7:0]    overrun;

   // Core model: returns tok_val for processor tok_id on its core_valid cycle.
   logic [IW-1:0] tok_id;
   logic [1:0]    tok_val;
   assign token_startstop = (core_valid && processor_id == tok_id) ? tok_val : 2'b00;

   int n_checks = 0;
   int n_fail   = 0;

   ttt_core_scheduler #(.NUM_PROCESSORS(N), .PROG_WIDTH(PW)) dut (
      .clock_fast      (clock_fast),
      .reset_n         (reset_n),
      .tick            (tick),
      .processor_id    (processor_id),
      .core_valid      (core_valid),
      .token_startstop (token_startstop),
      .event_valid     (event_valid),
      .event_ready     (event_ready),
      .event_id        (event_id),
      .event_type      (event_type),
      .prog_req        (prog_req),
      .prog_id         (prog_id),
      .prog_instr      (prog_instr),
      .prog_data_in    (prog_data_in),
      .prog_ack        (prog_ack),
      .prog_err        (prog_err),
      .instruction     (instruction),
      .prog_data       (prog_data),
      .sweep_busy      (sweep_busy),
      .sweep_done      (sweep_done),
      .overrun         (overrun)
   );

   always #5 clock_fast = ~clock_fast;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge, where inputs are driven.
   task automatic cyc();
      @(posedge clock_fast);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_id"},    32'(processor_id), 0);
      check({pfx, "_cv"},    32'(core_valid),   0);
      check({pfx, "_ev"},    32'(event_valid),  0);
      check({pfx, "_evid"},  32'(event_id),     0);
      check({pfx, "_evty"},  32'(event_type),   0);
      check({pfx, "_instr"}, 32'(instruction),  0);
      check({pfx, "_pdata"}, 32'(prog_data),    0);
      check({pfx, "_ack"},   32'(prog_ack),     0);
      check({pfx, "_err"},   32'(prog_err),     0);
      check({pfx, "_busy"},  32'(sweep_busy),   0);
      check({pfx, "_done"},  32'(sweep_done),   0);
      check({pfx, "_ovr"},   32'(overrun),      0);
   endtask

   // Hold tick for whole sweep periods (1 start + N overruns per period).
   task automatic run_ticks(input int periods);
      tick = 1'b1;
      repeat ((N + 1) * periods) cyc();
      tick = 1'b0;
      settle();
   endtask

   initial begin
      reset_n      = 1'b0;
      tick         = 1'b0;
      event_ready  = 1'b0;
      prog_req     = 1'b0;
      prog_id      = '0;
      prog_instr   = 3'd0;
      prog_data_in = '0;
      tok_id       = '1;
      tok_val      = 2'b00;
      #1;
      check_reset("por");
      repeat (2) @(posedge clock_fast);
      #1;
      reset_n = 1'b1;
      settle();
      check("idle_busy", 32'(sweep_busy), 0);

      // Plain sweep, no tokens, no back-pressure.
      event_ready = 1'b1;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      for (int i = 0; i < N; i++) begin
         settle();
         check("a_cv",   32'(core_valid),   1);
         check("a_id",   32'(processor_id), i);
         check("a_ev",   32'(event_valid),  0);
         check("a_busy", 32'(sweep_busy),   1);
         check("a_done", 32'(sweep_done),   0);
         cyc();
      end
      settle();
      check("a_done_hi", 32'(sweep_done),   1);
      check("a_busy_lo", 32'(sweep_busy),   0);
      check("a_cv_lo",   32'(core_valid),   0);
      check("a_id0",     32'(processor_id), 0);
      check("a_ev_lo",   32'(event_valid),  0);
      cyc();
      settle();
      check("a_done_pulse", 32'(sweep_done), 0);

      // Start token at id 3 with event_ready low for 4 cycles.
      tok_id = 4'd3;
      tok_val = 2'b01;
      event_ready = 1'b0;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("b_cv", 32'(core_valid),   1);
         check("b_id", 32'(processor_id), i);
         cyc();
      end
      for (int k = 0; k < 4; k++) begin
         settle();
         check("b_stall_cv", 32'(core_valid),   0);
         check("b_stall_id", 32'(processor_id), 4);
         check("b_ev",       32'(event_valid),  1);
         check("b_evid",     32'(event_id),     3);
         check("b_evty",     32'(event_type),   1);
         cyc();
      end
      event_ready = 1'b1;
      settle();
      check("b_resume_cv", 32'(core_valid),   1);
      check("b_resume_id", 32'(processor_id), 4);
      cyc();
      settle();
      check("b_drained", 32'(event_valid), 0);
      for (int i = 5; i < N; i++) begin
         settle();
         check("b_tail_id", 32'(processor_id), i);
         cyc();
      end
      settle();
      check("b_done", 32'(sweep_done), 1);
      tok_id = '1;
      cyc();

      // Tick and programming request together: tick wins, PROG follows.
      prog_req     = 1'b1;
      prog_id      = 4'd2;
      prog_instr   = 3'd5;
      prog_data_in = 8'hA5;
      tick         = 1'b1;
      cyc();
      tick = 1'b0;
      for (int i = 0; i < N; i++) begin
         settle();
         check("c_id",    32'(processor_id), i);
         check("c_ack",   32'(prog_ack),     0);
         check("c_instr", 32'(instruction),  0);
         cyc();
      end
      settle();
      check("c_done",     32'(sweep_done),  1);
      check("c_done_ack", 32'(prog_ack),    0);
      cyc();
      settle();
      check("c_prog_id",    32'(processor_id), 2);
      check("c_prog_instr", 32'(instruction),  5);
      check("c_prog_data",  32'(prog_data),    'hA5);
      check("c_prog_ack",   32'(prog_ack),     1);
      check("c_prog_err",   32'(prog_err),     0);
      check("c_prog_cv",    32'(core_valid),   0);
      prog_req = 1'b0;
      cyc();
      settle();
      check("c_after_ack",   32'(prog_ack),     0);
      check("c_after_instr", 32'(instruction),  0);
      check("c_after_id",    32'(processor_id), 0);

      // prog_req held across the ack starts a second pass.
      prog_req     = 1'b1;
      prog_id      = 4'd1;
      prog_instr   = 3'd3;
      prog_data_in = 8'h3C;
      cyc();
      settle();
      check("d_ack1",   32'(prog_ack),    1);
      check("d_instr1", 32'(instruction), 3);
      cyc();
      settle();
      check("d_gap_ack",   32'(prog_ack),    0);
      check("d_gap_instr", 32'(instruction), 0);
      cyc();
      settle();
      check("d_ack2", 32'(prog_ack),  1);
      check("d_data", 32'(prog_data), 'h3C);
      prog_req = 1'b0;
      cyc();
      settle();
      check("d_ack_lo", 32'(prog_ack), 0);

      // Out-of-range prog_id, plus a tick during the PROG cycle.
      prog_req   = 1'b1;
      prog_id    = 4'd12;
      prog_instr = 3'd5;
      cyc();
      prog_req = 1'b0;
      settle();
      check("e_ack",   32'(prog_ack),    1);
      check("e_err",   32'(prog_err),    1);
      check("e_instr", 32'(instruction), 0);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      settle();
      check("e_ack_lo", 32'(prog_ack),   0);
      check("e_err_lo", 32'(prog_err),   0);
      check("e_ovr",    32'(overrun),    1);
      check("e_busy",   32'(sweep_busy), 0);
      cyc();
      settle();
      check("e_not_queued", 32'(sweep_busy), 0);

      // Overrun accumulation up to and past saturation.
      run_ticks(1);
      check("f_done", 32'(sweep_done), 1);
      check("f_ovr11", 32'(overrun), CNT_EN ? 11 : 1);
      run_ticks(24);
      check("f_ovr251", 32'(overrun), CNT_EN ? 251 : 1);
      run_ticks(1);
      check("f_ovr_sat", 32'(overrun), CNT_EN ? 255 : 1);

      // Reset at id 6 with a pending event, then restart.
      tok_id  = 4'd5;
      tok_val = 2'b11;
      event_ready = 1'b1;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat (6) cyc();
      event_ready = 1'b0;
      settle();
      check("g_id6",  32'(processor_id), 6);
      check("g_ev",   32'(event_valid),  1);
      check("g_evid", 32'(event_id),     5);
      check("g_evty", 32'(event_type),   3);
      reset_n = 1'b0;
      #1;
      check_reset("rst");
      cyc();
      cyc();
      reset_n = 1'b1;
      tok_id = '1;
      event_ready = 1'b1;
      settle();
      check("g_idle_busy", 32'(sweep_busy),  0);
      check("g_idle_ev",   32'(event_valid), 0);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      settle();
      check("g_restart_cv",   32'(core_valid),   1);
      check("g_restart_id",   32'(processor_id), 0);
      check("g_restart_busy", 32'(sweep_busy),   1);
      check("g_restart_ev",   32'(event_valid),  0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ttt_core_scheduler.md
TTT_CORE_SCHEDULER -- requirements
Module: ttt_core_scheduler

Interface
REQ-001 SHALL have parameter NUM_PROCESSORS, default 10, number of processors time-multiplexed on the core.
REQ-002 SHALL have parameter PROG_WIDTH, default 8, width of programming data.
REQ-003 SHALL have port clock_fast, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port tick, input, 1, one-cycle strobe requesting a sweep over all processors.
REQ-006 SHALL have port processor_id, output, $clog2(NUM_PROCESSORS), processor addressed on the core.
REQ-007 SHALL have port core_valid, output, 1, core evaluates processor_id this cycle.
REQ-008 SHALL have port token_startstop, input, 2, core result for processor_id in the same cycle: bit0 start, bit1 stop.
REQ-009 SHALL have ports event_valid (output, 1), event_ready (input, 1), event_id (output, $clog2(NUM_PROCESSORS)) and event_type (output, 2), forming the valid/ready event stream.
REQ-010 SHALL have ports prog_req (input, 1), prog_id (input, $clog2(NUM_PROCESSORS)), prog_instr (input, 3) and prog_data_in (input, PROG_WIDTH), the programming request.
REQ-011 SHALL have ports prog_ack (output, 1) and prog_err (output, 1), one-cycle completion pulses.
REQ-012 SHALL have ports instruction (output, 3) and prog_data (output, PROG_WIDTH), driven to the core.
REQ-013 SHALL have ports sweep_busy (output, 1), sweep_done (output, 1, pulse) and overrun (output, 8).

Function
REQ-014 SHALL implement the FSM states IDLE, SWEEP and PROG.
REQ-015 SHALL, in IDLE, go to SWEEP on tick with processor_id=0; otherwise SHALL go to PROG on prog_req; tick SHALL win a simultaneous tick and prog_req.
REQ-016 SHALL, in SWEEP, assert core_valid when the event register is empty or event_ready=1; processor_id SHALL advance by 1 after each core_valid cycle and hold otherwise (stall).
REQ-017 SHALL, on a core_valid cycle with token_startstop!=0, load event_id=processor_id and event_type=token_startstop and set event_valid=1; token_startstop=0 SHALL create no event.
REQ-018 SHALL clear event_valid on event_valid&&event_ready unless it is reloaded in the same cycle; a simultaneous drain and load SHALL keep event_valid=1 with the new contents.
REQ-019 SHALL keep event_id and event_type stable while event_valid=1 and event_ready=0.
REQ-020 SHALL, after the core_valid cycle for id NUM_PROCESSORS-1, return to IDLE and pulse sweep_done for 1 cycle, with processor_id returning to 0; a pending event SHALL stay valid.
REQ-021 SHALL set sweep_busy=1 exactly while in SWEEP.
REQ-022 SHALL count a tick arriving in SWEEP or PROG as an overrun; the tick SHALL otherwise be ignored (not queued).
REQ-023 SHALL, in PROG, for 1 cycle drive processor_id=prog_id, instruction=prog_instr and prog_data=prog_data_in, pulse prog_ack and return to IDLE.
REQ-024 SHALL, if prog_id>=NUM_PROCESSORS, pulse prog_ack and prog_err together with instruction kept at 0.
REQ-025 SHALL hold instruction=0 (NOP) in all cycles other than a valid PROG cycle; prog_req held after ack SHALL start a new PROG pass.
REQ-026 SHALL keep core_valid=0 outside SWEEP.
REQ-027 SHALL meet this latency: tick at cycle t gives the first core_valid at t+1; with no stalls, sweep_done is at t+NUM_PROCESSORS+1.

Reset
REQ-028 SHALL, on reset_n=0, immediately (asynchronously) enter IDLE with processor_id=0, core_valid=0, event_valid=0, event_id=0, event_type=0, instruction=0, prog_data=0, prog_ack=0, prog_err=0, sweep_busy=0, sweep_done=0 and overrun=0.
REQ-029 SHALL, on reset mid-sweep or mid-PROG, abandon the operation and drop any pending event; the first tick after release SHALL start a sweep at id 0.

Configuration
REQ-030 SHALL, with TTT_SCHED_OVERRUN_CNT_EN defined, make overrun an 8-bit saturating count of overrun ticks that holds at 255.
REQ-031 SHALL, without TTT_SCHED_OVERRUN_CNT_EN, make overrun[0] a sticky flag set by the first overrun, with overrun[7:1]=0.
REQ-032 SHALL clear overrun only by reset in both configurations.

Verification
REQ-033 SHALL cover: event_ready=1, token_startstop=0 always, tick at cycle 5 -> core_valid cycles 6..15 with ids 0..9, sweep_done at 16, no event_valid.
REQ-034 SHALL cover: token_startstop=01 at id 3, event_ready=0 for 4 cycles -> event_id=3, event_type=01 held; no core_valid for ids 4+ until ready; sweep resumes at id 4.
REQ-035 SHALL cover: tick and prog_req (prog_id=2, prog_instr=5, prog_data_in=0xA5) on the same cycle -> full sweep first, then 1 cycle with processor_id=2, instruction=5, prog_data=0xA5 and prog_ack.
REQ-036 SHALL cover: prog_req with prog_id=12 -> prog_ack=1, prog_err=1, instruction=0.
REQ-037 SHALL cover: 300 ticks during sweeps -> overrun=255 with the macro, overrun=1 without.
REQ-038 SHALL cover: reset_n low at id 6 with event_valid=1 -> all outputs at reset values in the same cycle; after release, a tick restarts at id 0.
